// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states
// and the wait-state limit.
package dmem_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_ILL = 2'b11;

  localparam int WAIT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between right-justified CPU data and the 32-bit memory word:
// store byte enables / lane data, and load extraction with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdword,
  output logic [3:0]  be,
  output logic [31:0] wdata_pos,
  output logic [31:0] rdata_ext
);

  logic [1:0]  blane;
  logic        hlane;
  logic [7:0]  rb;
  logic [15:0] rh;

  always_comb begin
    blane = BIG_ENDIAN ? (2'd3 - addr_lo) : addr_lo;
    // hlane 0 selects bits [15:0], 1 selects bits [31:16]
    hlane = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
    rb    = rdword[{blane, 3'b000} +: 8];
    rh    = rdword[{hlane, 4'b0000} +: 16];

    be        = 4'b0000;
    wdata_pos = 32'h0;
    rdata_ext = 32'h0;
    // Replicating the store data lets the byte enables alone pick the lane.
    case (size)
      SIZE_B: begin
        be        = 4'b0001 << blane;
        wdata_pos = {4{wdata[7:0]}};
        rdata_ext = {{24{rb[7] & ~uns}}, rb};
      end
      SIZE_H: begin
        be        = hlane ? 4'b1100 : 4'b0011;
        wdata_pos = {2{wdata[15:0]}};
        rdata_ext = {{16{rh[15] & ~uns}}, rh};
      end
      SIZE_W: begin
        be        = 4'b1111;
        wdata_pos = wdata;
        rdata_ext = rdword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory with valid/ready request, programmable wait states and a one-cycle
// response pulse; bad accesses report resp_err and never touch the array.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0,
  parameter int BIG_ENDIAN  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit NO_WAIT = (WAIT_STATES == 0);
  localparam logic [ADDR_W-2:0] DEPTH_L = (ADDR_W-1)'(DEPTH_WORDS);

  if (WAIT_STATES < 0 || WAIT_STATES > WAIT_MAX) begin : g_bad_ws
    $error("dmem_ctrl: WAIT_STATES out of range");
  end

  state_e            state;
  logic [3:0]        wait_cnt;
  logic              l_we, l_uns;
  logic [1:0]        l_size;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]       l_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic              accept, fire, err;
  logic              a_we, a_uns;
  logic [1:0]        a_size;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_wdata;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        be;
  logic [31:0]       wpos, rext;

  assign accept = req_valid && req_ready && rst_n;
  // With no wait states the access edge is the accept edge, so use live inputs.
  assign fire   = (accept && NO_WAIT) || (state == WAIT && wait_cnt == 4'd1);

  assign a_we    = accept ? req_we       : l_we;
  assign a_uns   = accept ? req_unsigned : l_uns;
  assign a_size  = accept ? req_size     : l_size;
  assign a_addr  = accept ? req_addr     : l_addr;
  assign a_wdata = accept ? req_wdata    : l_wdata;
  assign idx     = a_addr[IDX_W+1:2];

  assign err = (a_size == SIZE_ILL)
            || (a_size == SIZE_H && a_addr[0])
            || (a_size == SIZE_W && a_addr[1:0] != 2'b00)
            || ({1'b0, a_addr[ADDR_W-1:2]} >= DEPTH_L);

  dmem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN != 0)) u_align (
    .size      (a_size),
    .addr_lo   (a_addr[1:0]),
    .uns       (a_uns),
    .wdata     (a_wdata),
    .rdword    (mem[idx]),
    .be        (be),
    .wdata_pos (wpos),
    .rdata_ext (rext)
  );

  always_ff @(posedge clk) begin
    if (fire && !err && a_we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wpos[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      wait_cnt   <= 4'd0;
      l_we       <= 1'b0;
      l_uns      <= 1'b0;
      l_size     <= SIZE_B;
      l_addr     <= '0;
      l_wdata    <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      if (fire) begin
        resp_valid <= 1'b1;
        resp_rdata <= (err || a_we) ? 32'h0 : rext;
        resp_err   <= err;
      end
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            l_we     <= req_we;
            l_uns    <= req_unsigned;
            l_size   <= req_size;
            l_addr   <= req_addr;
            l_wdata  <= req_wdata;
            wait_cnt <= 4'(WAIT_STATES);
            if (NO_WAIT) begin
              state     <= RESP;
              req_ready <= 1'b1;
            end else begin
              state     <= WAIT;
              req_ready <= 1'b0;
            end
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state     <= RESP;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
